// File: rtl/ntom_xbar_rr_if.sv
// ntom_xbar_rr_if: request-side and output-side bundle of the N-to-M crossbar.
// Handshake: a beat moves across a port in any cycle where its valid and
// ready are both high at the rising clock edge; the source keeps valid,
// payload, select and last stable until that happens.
interface ntom_xbar_rr_if #(
   parameter int N         = 8,
   parameter int M         = 4,
   parameter int PLD_WIDTH = 32
);
   localparam int SEL_W = $clog2(M);

   logic [N-1:0]         in_vld;
   logic [PLD_WIDTH-1:0] in_pld    [N];
   logic [SEL_W-1:0]     in_select [N];
   logic [N-1:0]         in_last;
   logic [N-1:0]         in_rdy;
   logic [M-1:0]         out_vld;
   logic [PLD_WIDTH-1:0] out_pld   [M];
   logic [M-1:0]         out_last;
   logic [M-1:0]         out_rdy;

   // Request sources plus downstream sinks.
   modport master (
      output in_vld, in_pld, in_select, in_last, out_rdy,
      input  in_rdy, out_vld, out_pld, out_last
   );

   // The crossbar itself.
   modport slave (
      input  in_vld, in_pld, in_select, in_last, out_rdy,
      output in_rdy, out_vld, out_pld, out_last
   );
endinterface

// File: rtl/ntom_xbar_rr.sv
// ntom_xbar_rr: N-input, M-output request crossbar. Each output has its own
// round-robin arbiter and a registered 2-entry buffer. Packet locking (an
// output stays with one input until that input's last beat) is built when
// NTOM_XBAR_PKT_LOCK_EN is defined; otherwise every beat is arbitrated alone.
module ntom_xbar_rr #(
   parameter int N         = 8,
   parameter int M         = 4,
   parameter int PLD_WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   ntom_xbar_rr_if.slave  bus
);
   localparam int SEL_W = $clog2(M);
   localparam int PTR_W = $clog2(N);

   logic [PTR_W-1:0]     ptr       [M];
   logic [1:0]           buf_cnt   [M];
   logic [PLD_WIDTH-1:0] head_pld  [M];
   logic [PLD_WIDTH-1:0] tail_pld  [M];
   logic [M-1:0]         head_last;
   logic [M-1:0]         tail_last;

   logic [M-1:0]         gnt_vld;
   logic [PTR_W-1:0]     gnt_idx   [M];
   logic [N-1:0]         gnt_mask;
   logic [M-1:0]         push;
   logic [M-1:0]         pop;

`ifdef NTOM_XBAR_PKT_LOCK_EN
   typedef enum logic {LK_IDLE, LK_LOCKED} lock_t;
   lock_t            lock_state [M];
   lock_t            lock_next  [M];
   logic [PTR_W-1:0] owner      [M];
   logic [PTR_W-1:0] owner_next [M];
`endif

   // Round-robin search per output, starting at its pointer; only outputs with
   // buffer room grant, and a locked output only considers its owner.
   always_comb begin
      gnt_vld  = '0;
      gnt_mask = '0;
      for (int j = 0; j < M; j++) gnt_idx[j] = '0;
      for (int j = 0; j < M; j++) begin
         if (buf_cnt[j] != 2'd2) begin
            for (int k = 0; k < N; k++) begin
`ifdef NTOM_XBAR_PKT_LOCK_EN
               if (!gnt_vld[j] && bus.in_vld[(int'(ptr[j]) + k) % N] &&
                   (bus.in_select[(int'(ptr[j]) + k) % N] == SEL_W'(j)) &&
                   ((lock_state[j] == LK_IDLE) ||
                    (owner[j] == PTR_W'((int'(ptr[j]) + k) % N)))) begin
`else
               if (!gnt_vld[j] && bus.in_vld[(int'(ptr[j]) + k) % N] &&
                   (bus.in_select[(int'(ptr[j]) + k) % N] == SEL_W'(j))) begin
`endif
                  gnt_vld[j] = 1'b1;
                  gnt_idx[j] = PTR_W'((int'(ptr[j]) + k) % N);
               end
            end
         end
         if (gnt_vld[j]) gnt_mask[gnt_idx[j]] = 1'b1;
      end
   end

   // Each input selects one output, so at most one bit of gnt_mask per input.
   assign bus.in_rdy = gnt_mask & {N{rst_n}};
   assign push       = gnt_vld;
   assign pop        = bus.out_vld & bus.out_rdy;

   // Outputs come straight from the buffer head registers.
   always_comb begin
      for (int j = 0; j < M; j++) begin
         bus.out_pld[j] = head_pld[j];
         bus.out_vld[j] = (buf_cnt[j] != 2'd0);
      end
   end
   assign bus.out_last = head_last;

   // Pointer update and 2-entry buffer (head/tail registers) per output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < M; j++) begin
            ptr[j]      <= '0;
            buf_cnt[j]  <= 2'd0;
            head_pld[j] <= '0;
            tail_pld[j] <= '0;
         end
         head_last <= '0;
         tail_last <= '0;
      end else begin
         for (int j = 0; j < M; j++) begin
            if (push[j]) ptr[j] <= PTR_W'((int'(gnt_idx[j]) + 1) % N);
            case ({push[j], pop[j]})
               2'b10: begin
                  if (buf_cnt[j] == 2'd0) begin
                     head_pld[j]  <= bus.in_pld[gnt_idx[j]];
                     head_last[j] <= bus.in_last[gnt_idx[j]];
                  end else begin
                     tail_pld[j]  <= bus.in_pld[gnt_idx[j]];
                     tail_last[j] <= bus.in_last[gnt_idx[j]];
                  end
                  buf_cnt[j] <= buf_cnt[j] + 2'd1;
               end
               2'b01: begin
                  head_pld[j]  <= tail_pld[j];
                  head_last[j] <= tail_last[j];
                  buf_cnt[j]   <= buf_cnt[j] - 2'd1;
               end
               2'b11: begin
                  if (buf_cnt[j] == 2'd1) begin
                     head_pld[j]  <= bus.in_pld[gnt_idx[j]];
                     head_last[j] <= bus.in_last[gnt_idx[j]];
                  end else begin
                     head_pld[j]  <= tail_pld[j];
                     head_last[j] <= tail_last[j];
                     tail_pld[j]  <= bus.in_pld[gnt_idx[j]];
                     tail_last[j] <= bus.in_last[gnt_idx[j]];
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef NTOM_XBAR_PKT_LOCK_EN
   // Lock state register per output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < M; j++) begin
            lock_state[j] <= LK_IDLE;
            owner[j]      <= '0;
         end
      end else begin
         for (int j = 0; j < M; j++) begin
            lock_state[j] <= lock_next[j];
            owner[j]      <= owner_next[j];
         end
      end
   end

   // Lock on a non-last beat from an idle output; release on the owner's last beat.
   always_comb begin
      for (int j = 0; j < M; j++) begin
         lock_next[j]  = lock_state[j];
         owner_next[j] = owner[j];
         if (push[j]) begin
            case (lock_state[j])
               LK_IDLE: begin
                  if (!bus.in_last[gnt_idx[j]]) begin
                     lock_next[j]  = LK_LOCKED;
                     owner_next[j] = gnt_idx[j];
                  end
               end
               LK_LOCKED: begin
                  if (bus.in_last[gnt_idx[j]]) lock_next[j] = LK_IDLE;
               end
               default: lock_next[j] = LK_IDLE;
            endcase
         end
      end
   end
`endif
endmodule

// File: tb/tb_ntom_xbar_rr.sv
// tb_ntom_xbar_rr: directed scenarios (reset, fairness, backpressure,
// parallel outputs, packet locking, reset mid-packet) with a per-output
// scoreboard of {last, payload} beats in acceptance order.
module tb_ntom_xbar_rr;
   localparam int N  = 8;
   localparam int M  = 4;
   localparam int PW = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_push   = 0;
   int   n_pop    = 0;
   int   seq      = 0;
   logic [PW:0] exp_q [M][$];

   // Clock / reset block
   always #5 clk = ~clk;

   ntom_xbar_rr_if #(.N(N), .M(M), .PLD_WIDTH(PW)) bus ();

   ntom_xbar_rr #(.N(N), .M(M), .PLD_WIDTH(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int i, input int sel, input logic last);
      bus.in_vld[i]    = 1'b1;
      bus.in_select[i] = 2'(sel);
      bus.in_last[i]   = last;
      bus.in_pld[i]    = {8'(i), 24'(seq)};
      seq++;
   endtask

   task automatic idle_inputs();
      bus.in_vld  = '0;
      bus.in_last = '0;
      for (int i = 0; i < N; i++) begin
         bus.in_pld[i]    = '0;
         bus.in_select[i] = '0;
      end
   endtask

   task automatic clear_sb();
      for (int j = 0; j < M; j++) exp_q[j].delete();
      n_push = 0;
      n_pop  = 0;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      idle_inputs();
      clear_sb();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      idle_inputs();
      bus.out_rdy = '1;
      repeat (5) @(negedge clk);
      for (int j = 0; j < M; j++) check_eq("drain_empty", 64'(exp_q[j].size()), 64'd0);
      check_eq("push_pop_match", 64'(n_pop), 64'(n_push));
   endtask

   // Scoreboard: pop/compare delivered beats, then push newly accepted beats.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int j = 0; j < M; j++) begin
            if (bus.out_vld[j] && bus.out_rdy[j]) begin
               n_pop++;
               check_eq("sb_avail", 64'(exp_q[j].size() != 0), 64'd1);
               if (exp_q[j].size() != 0)
                  check_eq("sb_data", 64'({bus.out_last[j], bus.out_pld[j]}), 64'(exp_q[j].pop_front()));
            end
         end
         for (int i = 0; i < N; i++) begin
            if (bus.in_vld[i] && bus.in_rdy[i]) begin
               n_push++;
               exp_q[bus.in_select[i]].push_back({bus.in_last[i], bus.in_pld[i]});
            end
         end
      end
   end

   initial begin
      int            order[$];
      int            exp_order[8];
      logic [N-1:0]  acc;
      logic [PW-1:0] prev_pld;
      logic [PW-1:0] first_pld;
      logic          prev_acc;
      int            b1;
      int            b2;

      // Reset with every input requesting
      idle_inputs();
      bus.out_rdy = '1;
      for (int i = 0; i < N; i++) set_beat(i, i % M, 1'b1);
      @(negedge clk);
      check_eq("rst_out_vld", 64'(bus.out_vld), 64'd0);
      check_eq("rst_in_rdy", 64'(bus.in_rdy), 64'd0);
      check_eq("rst_out_pld0", 64'(bus.out_pld[0]), 64'd0);
      check_eq("rst_out_last", 64'(bus.out_last), 64'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_first_grant", 64'(bus.in_rdy), 64'h0F);
      tick();
      idle_inputs();
      @(negedge clk);
      check_eq("rst_first_out_vld", 64'(bus.out_vld), 64'hF);
      tick();
      drain();

      // Fairness: inputs 0,3,5 to output 1
      do_reset();
      bus.out_rdy = '1;
      set_beat(0, 1, 1'b1);
      set_beat(3, 1, 1'b1);
      set_beat(5, 1, 1'b1);
      order.delete();
      prev_acc = 1'b0;
      prev_pld = '0;
      for (int c = 0; c < 20 && order.size() < 6; c++) begin
         @(negedge clk);
         if (prev_acc) begin
            check_eq("fair_lat_vld", 64'(bus.out_vld[1]), 64'd1);
            check_eq("fair_lat_pld", 64'(bus.out_pld[1]), 64'(prev_pld));
         end
         acc      = bus.in_vld & bus.in_rdy;
         prev_acc = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               order.push_back(i);
               prev_acc = 1'b1;
               prev_pld = bus.in_pld[i];
            end
         end
         tick();
         for (int i = 0; i < N; i++) if (acc[i]) set_beat(i, 1, 1'b1);
      end
      exp_order = '{0, 3, 5, 0, 3, 5, 0, 0};
      check_eq("fair_count", 64'(order.size()), 64'd6);
      for (int k = 0; k < 6 && k < order.size(); k++)
         check_eq("fair_order", 64'(order[k]), 64'(exp_order[k]));
      drain();

      // Backpressure: output 2 stalled, input 4 streams to it
      do_reset();
      bus.out_rdy = 4'b1011;
      set_beat(4, 2, 1'b1);
      first_pld = bus.in_pld[4];
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("bp_in_rdy", 64'(bus.in_rdy[4]), 64'(c < 2));
         if (c >= 2) begin
            check_eq("bp_out_vld", 64'(bus.out_vld[2]), 64'd1);
            check_eq("bp_hold_pld", 64'(bus.out_pld[2]), 64'(first_pld));
         end
         acc = bus.in_vld & bus.in_rdy;
         tick();
         if (acc[4]) set_beat(4, 2, 1'b1);
      end
      bus.out_rdy[2] = 1'b1;
      @(negedge clk);
      check_eq("bp_no_comb_path", 64'(bus.in_rdy[4]), 64'd0);
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         acc = bus.in_vld & bus.in_rdy;
         tick();
         if (acc[4]) set_beat(4, 2, 1'b1);
      end
      drain();

      // Parallelism: inputs 4..7 to outputs 3..0
      do_reset();
      bus.out_rdy = '1;
      for (int i = 4; i < 8; i++) set_beat(i, 7 - i, 1'b0);
      @(negedge clk);
      check_eq("par_in_rdy", 64'(bus.in_rdy), 64'hF0);
      tick();
      idle_inputs();
      @(negedge clk);
      check_eq("par_out_vld", 64'(bus.out_vld), 64'hF);
      check_eq("par_out_last", 64'(bus.out_last), 64'h0);
      tick();
      drain();

      // Packets: input 2 then input 1, 4 beats each, to output 0
      do_reset();
      bus.out_rdy = '1;
      set_beat(2, 0, 1'b0);
      b1 = 0;
      b2 = 0;
      order.delete();
      for (int c = 0; c < 30 && (b1 < 4 || b2 < 4); c++) begin
         if (c == 1) set_beat(1, 0, 1'b0);
         @(negedge clk);
         acc = bus.in_vld & bus.in_rdy;
         if (acc[2]) order.push_back(2);
         if (acc[1]) order.push_back(1);
         tick();
         if (acc[2]) begin
            b2++;
            if (b2 < 4) set_beat(2, 0, b2 == 3);
            else bus.in_vld[2] = 1'b0;
         end
         if (acc[1]) begin
            b1++;
            if (b1 < 4) set_beat(1, 0, b1 == 3);
            else bus.in_vld[1] = 1'b0;
         end
      end
`ifdef NTOM_XBAR_PKT_LOCK_EN
      exp_order = '{2, 2, 2, 2, 1, 1, 1, 1};
`else
      exp_order = '{2, 1, 2, 1, 2, 1, 2, 1};
`endif
      check_eq("pkt_count", 64'(order.size()), 64'd8);
      for (int k = 0; k < 8 && k < order.size(); k++)
         check_eq("pkt_order", 64'(order[k]), 64'(exp_order[k]));
      drain();

      // Reset mid-packet with output 0 full
      do_reset();
      bus.out_rdy = 4'b1110;
      set_beat(2, 0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check_eq("mp_accept", 64'(bus.in_rdy), 64'h04);
         tick();
         set_beat(2, 0, 1'b0);
      end
      set_beat(1, 0, 1'b1);
      @(negedge clk);
      check_eq("mp_full_block", 64'(bus.in_rdy), 64'h00);
      check_eq("mp_buffered", 64'(exp_q[0].size()), 64'd2);
      tick();
      rst_n = 1'b0;
      clear_sb();
      @(negedge clk);
      check_eq("mp_rst_out_vld", 64'(bus.out_vld), 64'd0);
      check_eq("mp_rst_in_rdy", 64'(bus.in_rdy), 64'd0);
      tick();
      rst_n = 1'b1;
      bus.out_rdy = '1;
      @(negedge clk);
      check_eq("mp_empty_after", 64'(bus.out_vld), 64'd0);
      check_eq("mp_rr_from_0", 64'(bus.in_rdy), 64'h02);
      tick();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
